fifo_stream_reader: RTL and testbench



---
 rtl/fifo_stream_reader_pkg.sv | 9 +
 rtl/fifo_stream_reader_if.sv | 23 ++
 rtl/fifo_stream_reader_skid.sv | 57 +++++
 rtl/fifo_stream_reader.sv | 60 ++++++
 tb/tb_fifo_stream_reader.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and types for the FIFO read-side stream front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;
    localparam int BUF_DEPTH          = 2;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef logic [1:0] occ_t;
endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready stream port, grouped for the reader.
// Latency: n/a (wiring only).
// Backpressure: m_ready from the consumer; fifo_empty from the FIFO.
interface fifo_stream_reader_if import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();
    logic                  fifo_rd;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        output fifo_rd, m_valid, m_data,
        input  fifo_empty, fifo_rdata, m_ready
    );

    modport slave (
        input  fifo_rd, m_valid, m_data,
        output fifo_empty, fifo_rdata, m_ready
    );
endinterface

// File: rtl/fifo_stream_reader_skid.sv
// Two-entry in-order register buffer; head is always the oldest word.
// Latency: push visible at head one cycle later when the buffer was empty.
// Backpressure: none internally; the caller must never push into a full buffer without a pop.
module stream_skid_buffer import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output occ_t                  occ,
    output logic [DATA_WIDTH-1:0] head
);
    logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
    logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
    occ_t                  occ_q, occ_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        if (pop) begin
            ent0_d = ent1_q;
            occ_d  = occ_q - 2'd1;
        end
        // The tail slot is chosen from the occupancy left after any same-cycle pop.
        if (push) begin
            if (occ_d == 2'd0) begin
                ent0_d = push_data;
            end else begin
                ent1_d = push_data;
            end
            occ_d = occ_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = ent0_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && (occ_q == 2'(BUF_DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(pop && (occ_q == 2'd0)));
endmodule

// File: rtl/fifo_stream_reader.sv
// Converts the FIFO rd/empty pair with 1-cycle read data into a valid/ready stream source.
// Latency: fifo_rd in cycle T gives m_valid in T+2; sustains one word per cycle.
// Backpressure: reads are issued only against free buffer credit, so at most 2 words are absorbed.
module fifo_stream_reader import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    fifo_stream_reader_if.master bus,
    output logic [CNT_WIDTH-1:0] words_out
);
    occ_t                  occ;
    logic [DATA_WIDTH-1:0] head;
    logic                  pop;
    logic                  rd;
    logic [2:0]            credit_used;
    logic [2:0]            credit_lim;
    logic                  pend_q, pend_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    assign pop = bus.m_valid & bus.m_ready;

    // A same-cycle pop frees a slot, which is what lets m_ready keep reads going at full rate.
    always_comb begin
        credit_used = {1'b0, occ} + {2'b00, pend_q};
        credit_lim  = 3'(BUF_DEPTH) + {2'b00, pop};
        rd          = reset_n & en & ~bus.fifo_empty & (credit_used < credit_lim);
        pend_d      = rd;
        cnt_d       = pop ? (cnt_q + CNT_WIDTH'(1)) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    stream_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (pend_q),
        .push_data (bus.fifo_rdata),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

    assign bus.fifo_rd = rd;
    assign bus.m_valid = (occ != 2'd0);
    assign bus.m_data  = head;
    assign words_out   = cnt_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised and directed bench for fifo_stream_reader against a queue-based FIFO and stream model.
module tb_fifo_stream_reader;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic          en      = 1'b0;
    logic [CW-1:0] words_out;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .bus       (bus),
        .words_out (words_out)
    );

    always #5 clk = ~clk;

    int checks      = 0;
    int failures    = 0;
    int model_cnt   = 0;
    int outstanding = 0;
    int pops_total  = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: registered empty flag, read data one cycle after fifo_rd.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.fifo_empty <= 1'b1;
            bus.fifo_rdata <= '0;
        end else begin
            if (bus.fifo_rd) begin
                if (fq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fifo_underflow: fifo_rd=1 with FIFO empty at %0t", $time);
                end else begin
                    bus.fifo_rdata <= fq.pop_front();
                end
            end
            bus.fifo_empty <= (fq.size() == 0);
        end
    end

    // Monitor/scoreboard, sampling mid-cycle.
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_m_valid", 32'(bus.m_valid), 0);
            chk("rst_fifo_rd", 32'(bus.fifo_rd), 0);
            chk("rst_words_out", 32'(words_out), 0);
            chk("rst_m_data", 32'(bus.m_data), 0);
            prev_stall = 1'b0;
        end else begin
            chk("words_out", 32'(words_out), 32'(model_cnt % (1 << CW)));
            if (prev_stall) begin
                chk("hold_valid", 32'(bus.m_valid), 1);
                chk("hold_data", 32'(bus.m_data), 32'(prev_data));
            end
            if (bus.fifo_rd) begin
                chk("rd_needs_en", 32'(en), 1);
                chk("rd_needs_nonempty", 32'(bus.fifo_empty), 0);
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_word: got 0x%0h expected no word at %0t", bus.m_data, $time);
                end else begin
                    chk("data_order", 32'(bus.m_data), 32'(exp_q.pop_front()));
                end
                model_cnt++;
                pops_total++;
            end
            outstanding += int'(bus.fifo_rd) - int'(bus.m_valid && bus.m_ready);
            chk("outstanding_le_2", 32'(outstanding <= 2), 1);
            prev_stall = bus.m_valid & ~bus.m_ready;
            prev_data  = bus.m_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] v);
        fq.push_back(v);
        exp_q.push_back(v);
    endtask

    task automatic apply_reset(input int cycles);
        reset_n     = 1'b0;
        fq.delete();
        exp_q.delete();
        model_cnt   = 0;
        outstanding = 0;
        repeat (cycles) step();
    endtask

    // Returns at the negedge where fifo_rd is first seen high.
    task automatic wait_rd(input int max_cycles);
        bit ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (bus.fifo_rd) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_rd: no fifo_rd within %0d cycles", max_cycles);
        end
    endtask

    task automatic drain(input int max_cycles);
        bit ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if (exp_q.size() == 0 && outstanding == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL drain: %0d words still expected after %0d cycles", exp_q.size(), max_cycles);
        end
    endtask

    initial begin
        int            rd_cnt;
        int            pops_before;
        logic [DW-1:0] first_word;
        logic          exp_rd [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic          exp_vld[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [DW-1:0] exp_dat[6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};

        bus.m_ready = 1'b1;
        #1;
        apply_reset(2);

        // Preloaded three-word stream at full rate.
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        en = 1'b1;
        step();
        reset_n = 1'b1;
        wait_rd(10);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("t1_fifo_rd[%0d]", k), 32'(bus.fifo_rd), 32'(exp_rd[k]));
            chk($sformatf("t1_m_valid[%0d]", k), 32'(bus.m_valid), 32'(exp_vld[k]));
            if (exp_vld[k]) chk($sformatf("t1_m_data[%0d]", k), 32'(bus.m_data), 32'(exp_dat[k]));
        end
        chk("t1_words_out", 32'(words_out), 3);

        // Backpressure: only two reads absorbed, head holds, then gapless release.
        step();
        bus.m_ready = 1'b0;
        first_word  = 8'($urandom);
        push_word(first_word);
        for (int i = 0; i < 4; i++) push_word(8'($urandom));
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rd_cnt += int'(bus.fifo_rd);
        end
        chk("t2_rd_pulses", 32'(rd_cnt), 2);
        chk("t2_m_valid", 32'(bus.m_valid), 1);
        chk("t2_head", 32'(bus.m_data), 32'(first_word));
        step();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t2_no_gap[%0d]", i), 32'(bus.m_valid), 1);
        end
        drain(20);

        // Alternating m_ready over 16 words.
        for (int i = 0; i < 16; i++) push_word(8'($urandom));
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            step();
            bus.m_ready = ~bus.m_ready;
        end
        bus.m_ready = 1'b1;
        drain(20);

        // en dropped right after one read: the pending word still arrives, nothing more is read.
        en = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'($urandom));
        repeat (3) step();
        en = 1'b1;
        wait_rd(10);
        step();
        en          = 1'b0;
        pops_before = pops_total;
        rd_cnt      = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_cnt += int'(bus.fifo_rd);
        end
        chk("t4_no_rd_while_off", 32'(rd_cnt), 0);
        step();
        chk("t4_pending_delivered", 32'(pops_total - pops_before), 1);
        en = 1'b1;
        drain(20);

        // Reset while a word is buffered and another is in flight.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(8'($urandom));
        wait_rd(10);
        @(negedge clk);
        step();
        apply_reset(3);
        reset_n = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_word(8'($urandom));
        drain(20);
        chk("t5_words_out", 32'(words_out), 3);

        // Counter wrap with a 4-bit counter: 17 words leave it at 1.
        apply_reset(2);
        reset_n = 1'b1;
        for (int i = 0; i < 17; i++) push_word(8'($urandom));
        drain(40);
        chk("t6_words_out_wrap", 32'(words_out), 1);

        // Random traffic, en and backpressure.
        for (int i = 0; i < 400; i++) begin
            step();
            bus.m_ready = 1'($urandom_range(0, 1));
            en          = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0) push_word(8'($urandom));
        end
        step();
        en          = 1'b1;
        bus.m_ready = 1'b1;
        drain(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
